// File: rtl/acc_result_writer_if.sv
// acc_result_writer_if
//   Groups the two handshakes of the result writer.
//   Result side : wr_req / wr_data  (one word per cycle while wr_req is high)
//   Memory side : mem_we / mem_addr / mem_wdata, answered by mem_ack
//   slave  : the writer's view (takes results, drives the memory request)
//   master : the environment's view (accelerator + result memory)
interface acc_result_writer_if #(
   parameter int DATA_W = 21,
   parameter int ADDR_W = 6
);
   logic              wr_req;
   logic [DATA_W-1:0] wr_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;

   modport slave (
      input  wr_req, wr_data, mem_ack,
      output mem_we, mem_addr, mem_wdata
   );

   modport master (
      output wr_req, wr_data, mem_ack,
      input  mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/acc_result_writer.sv
// acc_result_writer
//   Buffers accelerator result words in a DEPTH-entry FIFO and drains them
//   to a single-port result memory at sequential addresses using a req/ack
//   write handshake. Once the accelerator has reported done and the FIFO is
//   empty, a one-cycle flush_done is raised.
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   start      run start pulse; accepted only when idle with an empty FIFO
//   acc_done   accelerator done pulse/level (latched)
//   bus        result input + memory write handshake (slave modport)
//   count      FIFO occupancy, 0..DEPTH
//   full       count == DEPTH
//   overflow   sticky: a result word was dropped because the FIFO was full
//   flush_done one-cycle pulse: run complete and memory up to date
module acc_result_writer #(
   parameter int DATA_W    = 21,
   parameter int DEPTH     = 8,
   parameter int ADDR_W    = 6,
   parameter int BASE_ADDR = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   acc_done,
   acc_result_writer_if.slave     bus,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   overflow,
   output logic                   flush_done
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

   state_t                        state_q, state_d;
   logic [DEPTH-1:0][DATA_W-1:0]  fifo_q;
   logic [PTR_W-1:0]              head_q, tail_q;
   logic [CNT_W-1:0]              count_q;
   logic                          we_q, we_d;
   logic [ADDR_W-1:0]             addr_q, addr_d;
   logic [DATA_W-1:0]             wdata_q, wdata_d;
   logic                          fd_q, fd_d;
   logic                          done_q, done_d;
   logic                          ovf_q, ovf_d;
   logic                          pop, push, start_ok;

   // mem_we is high exactly while in ISSUE, so an ack outside ISSUE is ignored
   assign pop      = (state_q == ISSUE) && bus.mem_ack;
   // a pop at the same edge frees the slot, so a full FIFO still accepts
   assign push     = bus.wr_req && (!full || pop);
   assign start_ok = start && (state_q == IDLE) && (count_q == '0);

   assign full       = (count_q == CNT_W'(DEPTH));
   assign count      = count_q;
   assign overflow   = ovf_q;
   assign flush_done = fd_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      fd_d    = 1'b0;
      done_d  = done_q | acc_done;
      ovf_d   = ovf_q | (bus.wr_req && !push);
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               state_d = ISSUE;
               we_d    = 1'b1;
               wdata_d = fifo_q[head_q];
            end else if (start_ok) begin
               // a new run begins; any pending done belongs to the old run
               addr_d = BASE;
               ovf_d  = 1'b0;
               done_d = 1'b0;
            end else if (done_q) begin
               state_d = FLUSH;
               fd_d    = 1'b1;
            end
         end
         ISSUE: begin
            if (bus.mem_ack) begin
               state_d = IDLE;
               we_d    = 1'b0;
               addr_d  = addr_q + 1'b1;
            end
         end
         FLUSH: begin
            state_d = IDLE;
            done_d  = acc_done;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= BASE;
         wdata_q <= '0;
         fd_q    <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         fd_q    <= fd_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // storage needs no reset: occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (push) fifo_q[tail_q] <= bus.wr_data;
   end
endmodule

// File: tb/tb_acc_result_writer.sv
// tb_acc_result_writer
//   Directed bench for acc_result_writer (DATA_W=21, DEPTH=8, ADDR_W=3).
//   A per-cycle vector table covers single word, burst/overflow, simultaneous
//   push+pop on a full FIFO, address wrap and start/done interplay; short
//   hand-written sequences cover backpressure and asynchronous reset.
module tb_acc_result_writer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       acc_done = 1'b0;
   logic [3:0] count;
   logic       full, overflow, flush_done;
   int         n_vec = 0;
   int         n_err = 0;

   acc_result_writer_if #(.DATA_W(21), .ADDR_W(3)) bif ();

   acc_result_writer #(.DATA_W(21), .DEPTH(8), .ADDR_W(3), .BASE_ADDR(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .acc_done   (acc_done),
      .bus        (bif.slave),
      .count      (count),
      .full       (full),
      .overflow   (overflow),
      .flush_done (flush_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st, dn, wr;
      logic [20:0] d;
      logic        ack;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];

   // expected outputs packed as {mem_we, mem_addr, mem_wdata, count, full, overflow, flush_done}
   function automatic logic [31:0] ex(int we, int a, int wd, int c, int f, int ov, int fd);
      return {1'(we), 3'(a), 21'(wd), 4'(c), 1'(f), 1'(ov), 1'(fd)};
   endfunction

   function automatic vec_t mk(int st, int dn, int wr, int d, int ack,
                               int we, int a, int wd, int c, int f, int ov, int fd);
      vec_t v;
      v.st = 1'(st); v.dn = 1'(dn); v.wr = 1'(wr); v.d = 21'(d); v.ack = 1'(ack);
      v.exp = ex(we, a, wd, c, f, ov, fd);
      return v;
   endfunction

   function automatic logic [31:0] obs();
      return {bif.mem_we, bif.mem_addr, bif.mem_wdata, count, full, overflow, flush_done};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(logic st, logic dn, logic wr, logic [20:0] d, logic ack);
      start = st; acc_done = dn; bif.wr_req = wr; bif.wr_data = d; bif.mem_ack = ack;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0);

      // ---- single word, ack tied high, then done -> flush pulse ----
      tbl.push_back(mk(1,0,0,0,1,         0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,1,'h1ABCDE,1,  0,0,0,1,0,0,0));
      tbl.push_back(mk(0,0,0,0,1,         1,0,'h1ABCDE,1,0,0,0));
      tbl.push_back(mk(0,0,0,0,1,         0,1,'h1ABCDE,0,0,0,0));
      tbl.push_back(mk(0,1,0,0,1,         0,1,'h1ABCDE,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,1,         0,1,'h1ABCDE,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1,         0,1,'h1ABCDE,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,1,         0,1,'h1ABCDE,0,0,0,0));
      // ---- burst of 8 with ack low ----
      tbl.push_back(mk(1,0,0,0,0,         0,0,'h1ABCDE,0,0,0,0));
      tbl.push_back(mk(0,0,1,1,0,         0,0,'h1ABCDE,1,0,0,0));
      for (int k = 2; k <= 8; k++)
         tbl.push_back(mk(0,0,1,k,0,      1,0,1,k,int'(k == 8),0,0));
      // full: push and pop at the same edge -> count stays 8, no overflow
      tbl.push_back(mk(0,0,1,9,1,         0,1,1,8,1,0,0));
      // full, no pop -> word 10 dropped, overflow sticks
      tbl.push_back(mk(0,0,1,10,0,        1,1,2,8,1,1,0));
      // drain 2..9 to addresses 1..7 then wrap to 0
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tbl.push_back(mk(0,0,0,0,1, 1,(1+k)%8,2+k,8-k,0,1,0));
         tbl.push_back(mk(0,0,0,0,1,      0,(2+k)%8,2+k,7-k,0,1,0));
      end
      tbl.push_back(mk(0,0,0,0,1,         0,1,9,0,0,1,0));
      // ---- restart rules ----
      tbl.push_back(mk(0,0,1,'h15,0,      0,1,9,1,0,1,0));
      tbl.push_back(mk(1,0,0,0,0,         1,1,'h15,1,0,1,0));   // start with count>0 ignored
      tbl.push_back(mk(1,0,0,0,1,         0,2,'h15,0,0,1,0));   // start in ISSUE ignored
      tbl.push_back(mk(0,1,0,0,0,         0,2,'h15,0,0,1,0));
      tbl.push_back(mk(0,0,0,0,0,         0,2,'h15,0,0,1,1));
      tbl.push_back(mk(1,0,0,0,0,         0,2,'h15,0,0,1,0));   // start in FLUSH ignored
      tbl.push_back(mk(1,0,0,0,0,         0,0,'h15,0,0,0,0));   // accepted: addr 0, overflow clear
      tbl.push_back(mk(1,1,0,0,0,         0,0,'h15,0,0,0,0));   // start beats acc_done
      tbl.push_back(mk(0,0,0,0,0,         0,0,'h15,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,         0,0,'h15,0,0,0,0));

      // ---- reset state ----
      #3;
      chk("reset_state", obs(), ex(0,0,0,0,0,0,0));
      #4 rst = 1'b1;
      tick();

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].st, tbl[i].dn, tbl[i].wr, tbl[i].d, tbl[i].ack);
         tick();
         chk($sformatf("row%0d", i), obs(), tbl[i].exp);
      end

      // ---- backpressure: ack held off 5 cycles, exactly one pop ----
      drive(0, 0, 1, 'h0AAAA, 0);
      tick();
      chk("bp_push", obs(), ex(0,0,'h15,1,0,0,0));
      drive(0, 0, 1, 'h15555, 0);
      tick();
      chk("bp_latency", obs(), ex(1,0,'h0AAAA,2,0,0,0));
      drive(0, 0, 0, 0, 0);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("bp_hold%0d", c), obs(), ex(1,0,'h0AAAA,2,0,0,0));
      end
      drive(0, 0, 0, 0, 1);
      tick();
      chk("bp_ack", obs(), ex(0,1,'h0AAAA,1,0,0,0));
      drive(0, 0, 0, 0, 0);
      tick();
      chk("bp_next", obs(), ex(1,1,'h15555,1,0,0,0));
      drive(0, 0, 0, 0, 1);
      tick();
      chk("bp_ack2", obs(), ex(0,2,'h15555,0,0,0,0));

      // ---- asynchronous reset in the middle of ISSUE ----
      drive(0, 0, 1, 'h7, 0);
      tick();
      chk("rst_push", obs(), ex(0,2,'h15555,1,0,0,0));
      drive(0, 0, 0, 0, 0);
      tick();
      chk("rst_issue", obs(), ex(1,2,'h7,1,0,0,0));
      #2 rst = 1'b0;
      #1;
      chk("rst_async", obs(), ex(0,0,0,0,0,0,0));
      #3 rst = 1'b1;
      tick();
      chk("rst_idle", obs(), ex(0,0,0,0,0,0,0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
